// File: rtl/adma_dm_wr_arb.sv
// rtl/adma_dm_wr_arb.sv - write AW round-robin arbiter, per-channel outstanding limit and W-beat order steering; optional ADMA_WR_ARB_PRIO_EN adds chn_prio
module adma_dm_wr_arb #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int DST_ADDR_W     = 32,
  parameter int MST_ID_W       = 5,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_DST_DATA_W = 256,
  parameter int CHN_OSTD_MAX   = 2,
  parameter int ORD_DEPTH      = 4,
  parameter int DMA_CHN_NUM_W  = $clog2(DMA_CHN_NUM)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [DMA_CHN_NUM-1:0]                      req_vld,
  output logic [DMA_CHN_NUM-1:0]                      req_rdy,
  input  logic [DMA_CHN_NUM-1:0][MST_ID_W-1:0]        req_awid,
  input  logic [DMA_CHN_NUM-1:0][DST_ADDR_W-1:0]      req_awaddr,
  input  logic [DMA_CHN_NUM-1:0][ATX_LEN_W-1:0]       req_awlen,
  input  logic [DMA_CHN_NUM-1:0][1:0]                 req_awburst,
  input  logic [DMA_CHN_NUM-1:0][ATX_DST_DATA_W-1:0]  chn_wdata,
  input  logic [DMA_CHN_NUM-1:0]                      chn_wdata_vld,
  output logic [DMA_CHN_NUM-1:0]                      chn_wdata_rdy,
`ifdef ADMA_WR_ARB_PRIO_EN
  input  logic [DMA_CHN_NUM-1:0][1:0]                 chn_prio,
`endif
  output logic [DMA_CHN_NUM_W-1:0]                    atx_chn_id,
  output logic [MST_ID_W-1:0]                         atx_awid,
  output logic [DST_ADDR_W-1:0]                       atx_awaddr,
  output logic [ATX_LEN_W-1:0]                        atx_awlen,
  output logic [1:0]                                  atx_awburst,
  output logic                                        atx_vld,
  input  logic                                        atx_rdy,
  output logic [ATX_DST_DATA_W-1:0]                   atx_wdata,
  output logic                                        atx_wdata_vld,
  input  logic                                        atx_wdata_rdy,
  input  logic [DMA_CHN_NUM-1:0]                      atx_done,
  output logic [DMA_CHN_NUM-1:0]                      chn_ostd_full
);

  localparam int OSTD_W = $clog2(CHN_OSTD_MAX + 1);
  localparam int PTR_W  = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
  localparam int CNT_W  = $clog2(ORD_DEPTH + 2);

  logic [DMA_CHN_NUM-1:0][OSTD_W-1:0] ostd_cnt;
  logic [DMA_CHN_NUM_W-1:0]           rr_ptr;
  logic [DMA_CHN_NUM-1:0]             elig;
  logic                               grant_vld;
  logic [DMA_CHN_NUM_W-1:0]           grant_idx;
  logic                               slot_free;
  logic                               slot_fire;
  logic [CNT_W-1:0]                   inflight;

  logic [DMA_CHN_NUM_W-1:0]           ord_chn [ORD_DEPTH];
  logic [ATX_LEN_W-1:0]               ord_len [ORD_DEPTH];
  logic [PTR_W-1:0]                   wr_ptr;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [CNT_W-1:0]                   ord_cnt;
  logic                               ord_empty;
  logic [DMA_CHN_NUM_W-1:0]           head_chn;
  logic [ATX_LEN_W-1:0]               head_len;
  logic [ATX_LEN_W-1:0]               beat_cnt;
  logic                               beat_fire;
  logic                               beat_last;

`ifdef ADMA_WR_ARB_PRIO_EN
  logic [1:0]                         best_prio;
`endif

  // Eligibility: pending request, room under the channel limit, room in the in-flight window, free slot
  always_comb begin
    slot_fire = atx_vld & atx_rdy;
    slot_free = ~atx_vld | atx_rdy;
    inflight  = ord_cnt + CNT_W'(atx_vld & ~atx_rdy);
    elig      = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      elig[i] = req_vld[i] & (ostd_cnt[i] < OSTD_W'(CHN_OSTD_MAX)) &
                (inflight < CNT_W'(ORD_DEPTH)) & slot_free & ~rst;
    end
  end

  // Arbiter: scan from rr_ptr; with priority enabled a strictly higher level wins, ties keep rr order
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
`ifdef ADMA_WR_ARB_PRIO_EN
    best_prio = '0;
`endif
    for (int k = 0; k < DMA_CHN_NUM; k++) begin
`ifdef ADMA_WR_ARB_PRIO_EN
      if (elig[(int'(rr_ptr) + k) % DMA_CHN_NUM] &&
          (!grant_vld || chn_prio[(int'(rr_ptr) + k) % DMA_CHN_NUM] > best_prio)) begin
        grant_vld = 1'b1;
        grant_idx = DMA_CHN_NUM_W'((int'(rr_ptr) + k) % DMA_CHN_NUM);
        best_prio = chn_prio[(int'(rr_ptr) + k) % DMA_CHN_NUM];
      end
`else
      if (!grant_vld && elig[(int'(rr_ptr) + k) % DMA_CHN_NUM]) begin
        grant_vld = 1'b1;
        grant_idx = DMA_CHN_NUM_W'((int'(rr_ptr) + k) % DMA_CHN_NUM);
      end
`endif
    end
  end

  // Grant pulse back to the requesting channel
  always_comb begin
    req_rdy = '0;
    if (grant_vld) req_rdy[grant_idx] = 1'b1;
  end

  // Output slot and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      atx_vld     <= 1'b0;
      atx_chn_id  <= '0;
      atx_awid    <= '0;
      atx_awaddr  <= '0;
      atx_awlen   <= '0;
      atx_awburst <= '0;
      rr_ptr      <= '0;
    end else begin
      if (slot_free) begin
        atx_vld <= grant_vld;
        if (grant_vld) begin
          atx_chn_id  <= grant_idx;
          atx_awid    <= req_awid[grant_idx];
          atx_awaddr  <= req_awaddr[grant_idx];
          atx_awlen   <= req_awlen[grant_idx];
          atx_awburst <= req_awburst[grant_idx];
        end
      end
      if (grant_vld) begin
        rr_ptr <= (grant_idx == DMA_CHN_NUM_W'(DMA_CHN_NUM - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Per-channel outstanding counters; a grant and a done in the same cycle cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      ostd_cnt <= '0;
    end else begin
      for (int i = 0; i < DMA_CHN_NUM; i++) begin
        if (grant_vld && grant_idx == DMA_CHN_NUM_W'(i)) begin
          if (!atx_done[i]) ostd_cnt[i] <= ostd_cnt[i] + 1'b1;
        end else if (atx_done[i] && ostd_cnt[i] != '0) begin
          ostd_cnt[i] <= ostd_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Full flags per channel
  always_comb begin
    chn_ostd_full = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      chn_ostd_full[i] = (ostd_cnt[i] == OSTD_W'(CHN_OSTD_MAX));
    end
  end

  // W steering: only the channel at the order FIFO head is connected to the host
  always_comb begin
    ord_empty     = (ord_cnt == '0);
    head_chn      = ord_chn[rd_ptr];
    head_len      = ord_len[rd_ptr];
    atx_wdata     = chn_wdata[head_chn];
    atx_wdata_vld = ~ord_empty & chn_wdata_vld[head_chn];
    chn_wdata_rdy = '0;
    if (!ord_empty) chn_wdata_rdy[head_chn] = atx_wdata_rdy;
    beat_fire     = atx_wdata_vld & atx_wdata_rdy;
    beat_last     = beat_fire & (beat_cnt == head_len);
  end

  // Order FIFO storage, written when the host accepts an AW
  always_ff @(posedge clk) begin
    if (slot_fire) begin
      ord_chn[wr_ptr] <= atx_chn_id;
      ord_len[wr_ptr] <= atx_awlen;
    end
  end

  // Order FIFO pointers, occupancy and beat counter of the head transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ord_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (slot_fire) wr_ptr <= (wr_ptr == PTR_W'(ORD_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (beat_last) rd_ptr <= (rd_ptr == PTR_W'(ORD_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (slot_fire && !beat_last)      ord_cnt <= ord_cnt + 1'b1;
      else if (beat_last && !slot_fire) ord_cnt <= ord_cnt - 1'b1;
      if (beat_fire) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule
